fmul_round_pack: RTL and testbench
==================================

Name: fmul_round_pack

Overview:
- Stage directly downstream of the FMUL mantissa-product/normalise stage.
- Takes the normalised 24-bit significand, the widened signed biased exponent, guard/sticky bits, result sign and operand exception class.
- Performs IEEE-754 round-to-nearest-even, mantissa-carry renormalisation, overflow/underflow detection and special-value substitution.
- Packs a single-precision word and status flags behind a 2-stage valid/ready pipeline.

Parameters:
- EXP_W, 10, width of signed two's-complement biased input exponent; must be >= 10.
- QNAN, 32'h7FC0_0000, canonical quiet NaN emitted for NaN class.

Ports:
- clk  input  1  single clock; all state on rising edge
- rst_n  input  1  asynchronous, active-low reset
- in_valid  input  1  upstream result valid
- in_ready  output  1  block can accept this cycle
- in_sign  input  1  result sign (sign_1 ^ sign_2)
- in_exp  input  EXP_W  signed biased exponent after normalise shift
- in_man  input  24  normalised significand, bit 23 = hidden 1
- in_guard  input  1  first bit below LSB
- in_sticky  input  1  OR of all lower product bits
- in_exc  input  2  00 normal, 01 zero, 10 inf, 11 NaN
- out_valid  output  1  packed result valid
- out_ready  input  1  downstream accepts
- out_result  output  32  {sign, exp[7:0], frac[22:0]}
- out_flags  output  4  {invalid, overflow, underflow, inexact}

Behaviour:
- Reset (async assert, sync-safe deassert): out_valid=0, out_result=0, out_flags=0, both stage valids cleared. Asserting mid-operation discards in-flight data; out_valid drops in the same cycle rst_n falls.
- Handshake: transfer when valid&&ready on each side. s2 advances when !s2_valid||out_ready; s1 advances when !s1_valid||s2 advances; in_ready = that s1 condition (combinational, no input-to-output comb path except ready chain). out_* held stable while out_valid&&!out_ready.
- Latency: 2 cycles accept-to-out_valid; throughput 1/cycle when out_ready=1.
- Stage 1 (round): inc = in_guard & (in_man[0] | in_sticky); sum = {1'b0,in_man}+inc (25 bits); if sum[24]: man=sum[24:1], exp=in_exp+1 else man=sum[23:0], exp=in_exp. inexact_raw = in_guard|in_sticky. Register sign, exp (EXP_W), man[22:0], exc, inexact_raw.
- Stage 2 (classify/pack), priority order:
  - exc=11: QNAN, flags 1000.
  - exc=10: {sign,8'hFF,0}, flags 0000.
  - exc=01: {sign,31'b0}, flags 0000.
  - exp >= 255 (signed compare): {sign,8'hFF,0}, flags 0101.
  - exp <= 0 (signed): flush to {sign,31'b0}, flags 0011 (no subnormal output; matches hidden-bit = |exp convention).
  - else {sign,exp[7:0],man[22:0]}, flags {3'b000,inexact_raw}.
- Rounding carry into exponent 255 counts as overflow; carry from exp 0 to 1 still flushes (tininess before rounding).
- Simultaneous in/out transfer on a full pipe: no bubble, no loss, order preserved.

Decomposition:
- Shared fmul package: exception-class encodings (EXC_NORMAL/ZERO/INF/NAN), flag bit indices, QNAN constant, EXP_MAX=255.
- One natural sub-module: fmul_rne_round (stage-1 combinational incrementer/renormaliser), reusable by FADD.

Test Plan:
- exp=128, man=24'hC00000, g=0,s=0, exc=00, out_ready=1 -> 2 cycles later out_result=32'h4040_0000 (3.0), flags=0000.
- exp=127, man=24'hFFFFFF, g=1,s=0 -> carry renormalise: 32'h4000_0000, flags=0001; exp=127, man=24'h800000, g=1,s=0 (tie, LSB even) -> 32'h3F80_0000, flags=0001.
- exp=254, man=24'hFFFFFF, g=1 -> 32'h7F80_0000, flags=0101; sign=1, exp=10'h3F0 (-16) -> 32'h8000_0000, flags=0011.
- exc=11 with arbitrary exp/man -> 32'h7FC0_0000, flags=1000; exc=10, sign=1 -> 32'hFF80_0000, flags=0000.
- Stream 4 items, out_ready low for cycles 3-5 -> in_ready low once both stages full, out_result stable while stalled, all 4 emerge in order, none dropped/duplicated.
- rst_n pulsed low with 2 items in flight -> out_valid=0 immediately; after release, no stale item appears and next input emerges after 2 cycles.

Source files
------------

// File: rtl/fmul_round_pack_pkg.sv
// fmul_round_pack_pkg: shared FMUL encodings for exception classes, status flags and constants.
package fmul_round_pack_pkg;
   typedef enum logic [1:0] {
      EXC_NORMAL = 2'b00,
      EXC_ZERO   = 2'b01,
      EXC_INF    = 2'b10,
      EXC_NAN    = 2'b11
   } exc_e;
   localparam int FLAG_INV = 3;
   localparam int FLAG_OVF = 2;
   localparam int FLAG_UNF = 1;
   localparam int FLAG_INX = 0;
   localparam logic [31:0] QNAN_DEF = 32'h7FC0_0000;
   localparam int EXP_MAX = 255;
endpackage

// File: rtl/fmul_rne_round.sv
// fmul_rne_round: round-to-nearest-even increment with mantissa-carry renormalisation.
module fmul_rne_round #(
   parameter int EXP_W = 10
) (
   input  logic signed [EXP_W-1:0] i_exp,
   input  logic [23:0]             i_man,
   input  logic                    i_guard,
   input  logic                    i_sticky,
   output logic signed [EXP_W-1:0] o_exp,
   output logic [22:0]             o_frac,
   output logic                    o_inexact
);
   logic        w_inc;
   logic [24:0] w_sum;
   assign w_inc     = i_guard & (i_man[0] | i_sticky);
   assign w_sum     = {1'b0, i_man} + {24'b0, w_inc};
   // A carry out means the significand became 10.000..., so shift right and bump the exponent
   assign o_exp     = w_sum[24] ? i_exp + EXP_W'(1) : i_exp;
   assign o_frac    = w_sum[24] ? w_sum[23:1] : w_sum[22:0];
   assign o_inexact = i_guard | i_sticky;
endmodule

// File: rtl/fmul_round_pack.sv
// fmul_round_pack: FMUL round, classify and pack stage behind a 2-deep valid/ready pipeline.
module fmul_round_pack
   import fmul_round_pack_pkg::*;
#(
   parameter int          EXP_W = 10,
   parameter logic [31:0] QNAN  = QNAN_DEF
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic                    in_sign,
   input  logic signed [EXP_W-1:0] in_exp,
   input  logic [23:0]             in_man,
   input  logic                    in_guard,
   input  logic                    in_sticky,
   input  logic [1:0]              in_exc,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [31:0]             out_result,
   output logic [3:0]              out_flags
);
   localparam logic signed [EXP_W-1:0] EXP_TOP  = EXP_W'(EXP_MAX);
   localparam logic signed [EXP_W-1:0] EXP_ZERO = '0;

   logic                    w_s1_adv, w_s2_adv;
   logic signed [EXP_W-1:0] w_rexp;
   logic [22:0]             w_rfrac;
   logic                    w_rinx;
   logic [31:0]             w_res;
   logic [3:0]              w_flg;

   logic                    r_s1_valid, r_s2_valid;
   logic                    r_s1_sign, r_s1_inx, r_s1_tiny;
   logic signed [EXP_W-1:0] r_s1_exp;
   logic [22:0]             r_s1_frac;
   exc_e                    r_s1_exc;
   logic [31:0]             r_result;
   logic [3:0]              r_flags;

   assign w_s2_adv   = !r_s2_valid || out_ready;
   assign w_s1_adv   = !r_s1_valid || w_s2_adv;
   assign in_ready   = w_s1_adv;
   assign out_valid  = r_s2_valid;
   assign out_result = r_result;
   assign out_flags  = r_flags;

   fmul_rne_round #(.EXP_W(EXP_W)) u_round (
      .i_exp     (in_exp),
      .i_man     (in_man),
      .i_guard   (in_guard),
      .i_sticky  (in_sticky),
      .o_exp     (w_rexp),
      .o_frac    (w_rfrac),
      .o_inexact (w_rinx)
   );

   // Tininess is judged on the pre-rounding exponent, so a carry from 0 to 1 still flushes
   always_ff @(posedge clk) begin
      if (w_s1_adv && in_valid) begin
         r_s1_sign <= in_sign;
         r_s1_exp  <= w_rexp;
         r_s1_frac <= w_rfrac;
         r_s1_exc  <= exc_e'(in_exc);
         r_s1_inx  <= w_rinx;
         r_s1_tiny <= in_exp <= EXP_ZERO;
      end
   end

   always_comb begin
      w_res = {r_s1_sign, r_s1_exp[7:0], r_s1_frac};
      w_flg = '0;
      w_flg[FLAG_INX] = r_s1_inx;
      if (r_s1_exc == EXC_NAN) begin
         w_res = QNAN;
         w_flg = '0;
         w_flg[FLAG_INV] = 1'b1;
      end else if (r_s1_exc == EXC_INF) begin
         w_res = {r_s1_sign, 8'hFF, 23'b0};
         w_flg = '0;
      end else if (r_s1_exc == EXC_ZERO) begin
         w_res = {r_s1_sign, 31'b0};
         w_flg = '0;
      end else if (r_s1_exp >= EXP_TOP) begin
         w_res = {r_s1_sign, 8'hFF, 23'b0};
         w_flg = '0;
         w_flg[FLAG_OVF] = 1'b1;
         w_flg[FLAG_INX] = 1'b1;
      end else if (r_s1_tiny) begin
         w_res = {r_s1_sign, 31'b0};
         w_flg = '0;
         w_flg[FLAG_UNF] = 1'b1;
         w_flg[FLAG_INX] = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_s1_valid <= 1'b0;
         r_s2_valid <= 1'b0;
         r_result   <= '0;
         r_flags    <= '0;
      end else begin
         if (w_s1_adv) r_s1_valid <= in_valid;
         if (w_s2_adv) r_s2_valid <= r_s1_valid;
         if (w_s2_adv && r_s1_valid) begin
            r_result <= w_res;
            r_flags  <= w_flg;
         end
      end
   end
endmodule

// File: tb/tb_fmul_round_pack.sv
// tb_fmul_round_pack: directed vector table plus stall-stream and mid-flight reset sequences.
module tb_fmul_round_pack;
   logic        clk = 1'b0;
   logic        rst_n, in_valid, in_ready, in_sign, in_guard, in_sticky;
   logic [9:0]  in_exp;
   logic [23:0] in_man;
   logic [1:0]  in_exc;
   logic        out_valid, out_ready;
   logic [31:0] out_result;
   logic [3:0]  out_flags;

   always #5 clk = ~clk;

   fmul_round_pack #(.EXP_W(10)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .in_sign(in_sign), .in_exp(in_exp), .in_man(in_man), .in_guard(in_guard),
      .in_sticky(in_sticky), .in_exc(in_exc), .out_valid(out_valid),
      .out_ready(out_ready), .out_result(out_result), .out_flags(out_flags)
   );

   typedef struct {
      logic        sign;
      logic [9:0]  exp;
      logic [23:0] man;
      logic        g;
      logic        s;
      logic [1:0]  exc;
      logic [31:0] res;
      logic [3:0]  flg;
   } vec_t;

   vec_t v[15];
   int   n_pass = 0;
   int   n_total = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_total++;
      if (act === req) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, act, req);
   endtask

   task automatic drive(input vec_t x);
      in_sign = x.sign; in_exp = x.exp; in_man = x.man;
      in_guard = x.g; in_sticky = x.s; in_exc = x.exc;
   endtask

   initial begin
      int   sent, recv, extra;
      logic ir_low, stalled, stale;
      logic [31:0] held;
      v[0]  = '{1'b0, 10'd128,  24'hC00000, 1'b0, 1'b0, 2'b00, 32'h4040_0000, 4'b0000};
      v[1]  = '{1'b0, 10'd127,  24'hFFFFFF, 1'b1, 1'b0, 2'b00, 32'h4000_0000, 4'b0001};
      v[2]  = '{1'b0, 10'd127,  24'h800000, 1'b1, 1'b0, 2'b00, 32'h3F80_0000, 4'b0001};
      v[3]  = '{1'b0, 10'd254,  24'hFFFFFF, 1'b1, 1'b0, 2'b00, 32'h7F80_0000, 4'b0101};
      v[4]  = '{1'b1, 10'h3F0,  24'h800000, 1'b0, 1'b0, 2'b00, 32'h8000_0000, 4'b0011};
      v[5]  = '{1'b0, 10'd5,    24'h123456, 1'b1, 1'b1, 2'b11, 32'h7FC0_0000, 4'b1000};
      v[6]  = '{1'b1, 10'd100,  24'h800000, 1'b0, 1'b0, 2'b10, 32'hFF80_0000, 4'b0000};
      v[7]  = '{1'b0, 10'd200,  24'hABCDEF, 1'b1, 1'b0, 2'b01, 32'h0000_0000, 4'b0000};
      v[8]  = '{1'b0, 10'd0,    24'hFFFFFF, 1'b1, 1'b1, 2'b00, 32'h0000_0000, 4'b0011};
      v[9]  = '{1'b0, 10'd1,    24'h800000, 1'b0, 1'b0, 2'b00, 32'h0080_0000, 4'b0000};
      v[10] = '{1'b0, 10'd254,  24'hFFFFFE, 1'b1, 1'b1, 2'b00, 32'h7F7F_FFFF, 4'b0001};
      v[11] = '{1'b1, 10'd255,  24'h800000, 1'b0, 1'b0, 2'b00, 32'hFF80_0000, 4'b0101};
      v[12] = '{1'b0, 10'd128,  24'h800001, 1'b1, 1'b0, 2'b00, 32'h4000_0002, 4'b0001};
      v[13] = '{1'b0, 10'd128,  24'h800000, 1'b0, 1'b1, 2'b00, 32'h4000_0000, 4'b0001};
      v[14] = '{1'b1, 10'd300,  24'hFFFFFF, 1'b1, 1'b1, 2'b11, 32'h7FC0_0000, 4'b1000};

      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; drive(v[0]);
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("reset_out_valid", out_valid, 0);
      check("reset_out_result", out_result, 0);
      check("reset_out_flags", out_flags, 0);
      check("reset_in_ready", in_ready, 1);
      rst_n = 1'b1;

      for (int i = 0; i < 15; i++) begin
         @(posedge clk); #1;
         drive(v[i]); in_valid = 1'b1;
         @(posedge clk); #1;
         in_valid = 1'b0;
         @(posedge clk);
         @(negedge clk);
         check($sformatf("vec%0d_valid", i), out_valid, 1);
         check($sformatf("vec%0d_result", i), out_result, v[i].res);
         check($sformatf("vec%0d_flags", i), out_flags, v[i].flg);
      end

      sent = 0; recv = 0; extra = 0; ir_low = 1'b0; stalled = 1'b0; held = '0;
      for (int c = 0; c < 20; c++) begin
         @(posedge clk); #1;
         out_ready = !(c >= 3 && c <= 5);
         in_valid = sent < 4;
         if (sent < 4) drive(v[sent]);
         @(negedge clk);
         if (!in_ready) ir_low = 1'b1;
         if (stalled && out_valid) check("stall_hold", out_result, held);
         stalled = out_valid && !out_ready;
         held = out_result;
         if (out_valid && out_ready) begin
            if (recv < 4) check($sformatf("stream%0d_result", recv), out_result, v[recv].res);
            else extra++;
            recv++;
         end
         if (in_valid && in_ready) sent++;
      end
      in_valid = 1'b0;
      check("stream_in_ready_low", ir_low, 1);
      check("stream_sent", sent, 4);
      check("stream_recv", recv, 4);
      check("stream_extra", extra, 0);

      @(posedge clk); #1;
      out_ready = 1'b0; in_valid = 1'b1; drive(v[0]);
      @(posedge clk); #1;
      drive(v[1]);
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(negedge clk);
      check("pre_reset_valid", out_valid, 1);
      #2 rst_n = 1'b0;
      #1;
      check("rst_drop_valid", out_valid, 0);
      check("rst_drop_result", out_result, 0);
      @(negedge clk);
      rst_n = 1'b1; out_ready = 1'b1;
      stale = 1'b0;
      repeat (4) begin
         @(negedge clk);
         if (out_valid) stale = 1'b1;
      end
      check("no_stale_after_reset", stale, 0);
      @(posedge clk); #1;
      in_valid = 1'b1; drive(v[6]);
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(negedge clk);
      check("latency_not_early", out_valid, 0);
      @(negedge clk);
      check("latency_valid", out_valid, 1);
      check("latency_result", out_result, v[6].res);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
